// File: rtl/lc3b_stage_pipe_pkg.sv
// Shared types for the LC-3b handshaked stage register: payload bundle and occupancy states.
package lc3b_stage_pipe_pkg;

  localparam int LC3B_WORD_W = 16;
  localparam int LC3B_CS_W   = 4;
  localparam int LC3B_DRID_W = 3;

  typedef struct packed {
    logic [LC3B_WORD_W-1:0] address;
    logic [LC3B_WORD_W-1:0] data;
    logic [LC3B_WORD_W-1:0] npc;
    logic [LC3B_WORD_W-1:0] aluresult;
    logic [LC3B_WORD_W-1:0] ir;
    logic [LC3B_CS_W-1:0]   cs;
    logic [LC3B_DRID_W-1:0] drid;
  } lc3b_stage_bundle;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } lc3b_pipe_state;

endpackage

// File: rtl/lc3b_stage_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lc3b_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/lc3b_stage_pipe.sv
// Handshaked LC-3b inter-stage register with flush and stall counter.
// Define PIPE_SKID_EN for the two-entry skid version with a registered in_ready.
module lc3b_stage_pipe
  import lc3b_stage_pipe_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CS_W   = 4,
  parameter int DRID_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_address,
  input  logic [WORD_W-1:0] in_data,
  input  logic [WORD_W-1:0] in_npc,
  input  logic [WORD_W-1:0] in_aluresult,
  input  logic [WORD_W-1:0] in_ir,
  input  logic [CS_W-1:0]   in_cs,
  input  logic [DRID_W-1:0] in_drid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_address,
  output logic [WORD_W-1:0] out_data,
  output logic [WORD_W-1:0] out_npc,
  output logic [WORD_W-1:0] out_aluresult,
  output logic [WORD_W-1:0] out_ir,
  output logic [CS_W-1:0]   out_cs,
  output logic [DRID_W-1:0] out_drid,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_count,
  output lc3b_pipe_state    o_dbg_state
);

  localparam int BW = 5 * WORD_W + CS_W + DRID_W;

  lc3b_pipe_state r_state;
  logic [BW-1:0]  r_main;
  logic [BW-1:0]  w_in_bundle;
  logic           w_in_fire;
  logic           w_out_fire;
`ifdef PIPE_SKID_EN
  logic [BW-1:0]  r_skid;
`endif

  // Handshake: a bundle moves on an edge where valid and ready are both high on
  // that side; upstream holds valid and payload stable until it sees ready.
  assign w_in_bundle = {in_address, in_data, in_npc, in_aluresult, in_ir, in_cs, in_drid};
  assign {out_address, out_data, out_npc, out_aluresult, out_ir, out_cs, out_drid} = r_main;

  assign out_valid  = (r_state != EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

`ifdef PIPE_SKID_EN
  assign in_ready = (r_state != TWO) & ~flush & rst_n;
`else
  assign in_ready = (~out_valid | out_ready) & ~flush & rst_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
`ifdef PIPE_SKID_EN
      r_skid  <= '0;
`endif
    end else if (flush) begin
      // Payload is left in place; only occupancy is discarded.
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main  <= w_in_bundle;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_in_bundle;
`ifdef PIPE_SKID_EN
          end else if (w_in_fire) begin
            r_skid  <= w_in_bundle;
            r_state <= TWO;
`endif
          end else if (w_out_fire) begin
            r_state <= EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
`endif
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_dbg_state = r_state;

  lc3b_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (out_valid & ~out_ready),
    .i_clr   (stat_clr),
    .o_count (stall_count)
  );

endmodule

// File: tb/tb_lc3b_stage_pipe.sv
// Directed bench for lc3b_stage_pipe (4-bit stall counter); adapts to PIPE_SKID_EN.
module tb_lc3b_stage_pipe;
  import lc3b_stage_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush, stat_clr;
  logic [15:0] in_address, in_data, in_npc, in_aluresult, in_ir;
  logic [3:0]  in_cs;
  logic [2:0]  in_drid;
  logic [15:0] out_address, out_data, out_npc, out_aluresult, out_ir;
  logic [3:0]  out_cs;
  logic [2:0]  out_drid;
  logic [3:0]  stall_count;
  lc3b_pipe_state dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  lc3b_stage_pipe #(.WORD_W(16), .CS_W(4), .DRID_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_address(in_address), .in_data(in_data), .in_npc(in_npc),
    .in_aluresult(in_aluresult), .in_ir(in_ir), .in_cs(in_cs), .in_drid(in_drid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_address(out_address), .out_data(out_data), .out_npc(out_npc),
    .out_aluresult(out_aluresult), .out_ir(out_ir), .out_cs(out_cs), .out_drid(out_drid),
    .flush(flush), .stat_clr(stat_clr), .stall_count(stall_count),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every payload field is derived from ir so one value tags the whole bundle.
  task automatic set_in(input logic v, input logic [15:0] ir);
    in_valid     = v;
    in_ir        = ir;
    in_address   = ~ir;
    in_data      = {ir[7:0], ir[15:8]};
    in_npc       = ir + 16'd2;
    in_aluresult = ir << 1;
    in_cs        = ir[3:0];
    in_drid      = ir[6:4];
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; flush = 1'b0; stat_clr = 1'b0;
    set_in(1'b0, 16'h0000);
    #3;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready",  16'(in_ready),  16'd0);
    chk("rst_out_ir",    out_ir,         16'h0000);
    chk("rst_out_addr",  out_address,    16'h0000);
    chk("rst_stall",     16'(stall_count), 16'd0);
    #9;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 16'(in_ready), 16'd1);

    // Back-to-back stream with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 16'h1000 + 16'(i));
      #1;
      chk("stream_in_ready", 16'(in_ready), 16'd1);
      tick();
      chk("stream_valid", 16'(out_valid), 16'd1);
      chk("stream_ir",    out_ir, 16'h1000 + 16'(i));
      chk("stream_state", 16'(dbg_state), 16'(ONE));
    end
    chk("stream_addr", out_address,   16'hEFF8);
    chk("stream_data", out_data,      16'h0710);
    chk("stream_npc",  out_npc,       16'h1009);
    chk("stream_alu",  out_aluresult, 16'h200E);
    chk("stream_cs",   16'(out_cs),   16'h7);
    chk("stream_drid", 16'(out_drid), 16'h0);
    set_in(1'b0, 16'h0000);
    tick();
    chk("stream_drain_valid", 16'(out_valid), 16'd0);
    chk("stream_stall", 16'(stall_count), 16'd0);

    // Backpressure: two bundles against a stalled consumer
    out_ready = 1'b0;
    set_in(1'b1, 16'h00A1);
    #1;
    chk("bp_ready_first", 16'(in_ready), 16'd1);
    tick();
    chk("bp_valid_a1", 16'(out_valid), 16'd1);
    chk("bp_ir_a1",    out_ir, 16'h00A1);
    set_in(1'b1, 16'h00A2);
    #1;
`ifdef PIPE_SKID_EN
    chk("bp_ready_second", 16'(in_ready), 16'd1);
`else
    chk("bp_ready_second", 16'(in_ready), 16'd0);
`endif
    tick();
    chk("bp_ready_full", 16'(in_ready), 16'd0);
    chk("bp_ir_hold",    out_ir, 16'h00A1);
`ifdef PIPE_SKID_EN
    chk("bp_state_two", 16'(dbg_state), 16'(TWO));
    set_in(1'b0, 16'h0000);
`endif
    out_ready = 1'b1;
    #1;
    chk("bp_out_a1", out_ir, 16'h00A1);
    tick();
    set_in(1'b0, 16'h0000);
    #1;
    chk("bp_valid_a2", 16'(out_valid), 16'd1);
    chk("bp_out_a2",   out_ir, 16'h00A2);
    tick();
    chk("bp_drained", 16'(out_valid), 16'd0);
    chk("bp_stall",   16'(stall_count), 16'd1);

    // Flush with entries held
    out_ready = 1'b0;
    set_in(1'b1, 16'h00C1);
    tick();
    set_in(1'b1, 16'h00C2);
    tick();
    set_in(1'b0, 16'h0000);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 16'(in_ready), 16'd0);
    chk("flush_valid_before", 16'(out_valid), 16'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_valid_after", 16'(out_valid), 16'd0);
    chk("flush_in_ready_after", 16'(in_ready), 16'd1);
    chk("flush_state", 16'(dbg_state), 16'(EMPTY));
    chk("flush_keeps_stall", 16'(stall_count), 16'd3);
    out_ready = 1'b1;
    set_in(1'b1, 16'h00B0);
    tick();
    set_in(1'b0, 16'h0000);
    #1;
    chk("flush_b0_valid", 16'(out_valid), 16'd1);
    chk("flush_b0_ir",    out_ir, 16'h00B0);
    tick();
    chk("flush_b0_alone", 16'(out_valid), 16'd0);

    // Stall counter saturation and clear priority
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("cnt_clear", 16'(stall_count), 16'd0);
    out_ready = 1'b0;
    set_in(1'b1, 16'h00D0);
    tick();
    set_in(1'b0, 16'h0000);
    for (int i = 0; i < 20; i++) tick();
    chk("cnt_saturate", 16'(stall_count), 16'd15);
    chk("cnt_hold_ir",  out_ir, 16'h00D0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("cnt_clr_priority", 16'(stall_count), 16'd0);
    tick();
    chk("cnt_resume", 16'(stall_count), 16'd1);

    // Asynchronous reset between edges with both entries held
    set_in(1'b1, 16'h00E1);
    tick();
    set_in(1'b0, 16'h0000);
`ifdef PIPE_SKID_EN
    chk("arst_pre_state", 16'(dbg_state), 16'(TWO));
`else
    chk("arst_pre_state", 16'(dbg_state), 16'(ONE));
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(out_valid), 16'd0);
    chk("arst_ready", 16'(in_ready),  16'd0);
    chk("arst_ir",    out_ir,         16'h0000);
    chk("arst_stall", 16'(stall_count), 16'd0);
    chk("arst_state", 16'(dbg_state), 16'(EMPTY));
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("arst_discarded", 16'(out_valid), 16'd0);
    chk("arst_ready_after", 16'(in_ready), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
